irq_receiver: RTL and testbench

CPU-side endpoint of the irq_req/irq_code/irq_ack interrupt protocol. It accepts codes from a peripheral interrupt adapter, buffers them in a small FIFO and acknowledges each one. It presents them one at a time to the core as a trap request, and tracks the handler from trap entry until return. It sits between the peripheral interrupt sources and the core's trap/exception logic.

---
 rtl/irq_receiver_if.sv | 40 ++++
 rtl/irq_receiver.sv | 168 ++++++++++++++++
 tb/tb_irq_receiver.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/irq_receiver_if.sv
// Interrupt source handshake plus core trap/return signals of irq_receiver.
// The spurious counter exists only when IRQ_RECV_SPURIOUS_EN is defined.
interface irq_receiver_if #(
  parameter int FIFO_DEPTH = 4,
  parameter int CODE_WIDTH = 8
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic                  irq_req_i;
  logic [CODE_WIDTH-1:0] irq_code_bi;
  logic                  irq_ack_o;
  logic                  irq_en_i;
  logic                  trap_req_o;
  logic [CODE_WIDTH-1:0] trap_code_bo;
  logic                  trap_ack_i;
  logic                  irq_ret_i;
  logic [CNT_W-1:0]      pending_cnt_bo;
  logic                  busy_o;
`ifdef IRQ_RECV_SPURIOUS_EN
  logic [7:0]            spurious_cnt_bo;
`endif

  // Receiver side
  modport slave (
    input  irq_req_i, irq_code_bi, irq_en_i, trap_ack_i, irq_ret_i,
    output irq_ack_o, trap_req_o, trap_code_bo, pending_cnt_bo, busy_o
`ifdef IRQ_RECV_SPURIOUS_EN
    , output spurious_cnt_bo
`endif
  );

  // Source and core side
  modport master (
    output irq_req_i, irq_code_bi, irq_en_i, trap_ack_i, irq_ret_i,
    input  irq_ack_o, trap_req_o, trap_code_bo, pending_cnt_bo, busy_o
`ifdef IRQ_RECV_SPURIOUS_EN
    , input spurious_cnt_bo
`endif
  );
endinterface

// File: rtl/irq_receiver.sv
// Interrupt receiver: acks source codes into a FIFO and hands them to the core one trap at a time.
// Latency: request sampled at edge n -> ack in cycle n+1, trap_req_o in n+2 (empty FIFO, IDLE, enabled).
// Backpressure: full FIFO withholds the ack; the source holds its request. Optional: IRQ_RECV_SPURIOUS_EN.

module irq_receiver_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop_vld,
  output logic [WIDTH-1:0] head_dat,
  output logic [CNT_W-1:0] count,
  output logic             full
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  always_ff @(posedge clk_i) begin
    if (push_vld) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // Power-of-two depth: pointers wrap by natural overflow
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_vld) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_vld)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_vld, pop_vld})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign head_dat = mem[rd_ptr];
  assign full     = (count == CNT_W'(DEPTH));
endmodule

module irq_receiver #(
  parameter int FIFO_DEPTH = 4,
  parameter int CODE_WIDTH = 8
) (
  input logic           clk_i,
  input logic           rst_i,
  irq_receiver_if.slave bus
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t                state_q;
  state_t                state_d;
  logic                  ack_q;
  logic                  trap_req_q;
  logic                  trap_req_d;
  logic [CODE_WIDTH-1:0] trap_code_q;
  logic [CODE_WIDTH-1:0] trap_code_d;
  logic                  accept;
  logic                  push;
  logic                  pop;
  logic                  full;
  logic [CNT_W-1:0]      count;
  logic [CODE_WIDTH-1:0] head_dat;

  // The ack term masks the cycle where the source has not yet seen our ack
  assign accept = bus.irq_req_i && !ack_q && !full;

`ifdef IRQ_RECV_SPURIOUS_EN
  logic       spurious;
  logic [7:0] spurious_q;

  assign spurious = accept && (bus.irq_code_bi == '0);
  assign push     = accept && !spurious;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      spurious_q <= '0;
    end else if (spurious && (spurious_q != 8'hFF)) begin
      spurious_q <= spurious_q + 8'd1;
    end
  end

  assign bus.spurious_cnt_bo = spurious_q;
`else
  assign push = accept;
`endif

  irq_receiver_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CODE_WIDTH)
  ) u_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .push_vld (push),
    .push_dat (bus.irq_code_bi),
    .pop_vld  (pop),
    .head_dat (head_dat),
    .count    (count),
    .full     (full)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      ack_q       <= 1'b0;
      trap_req_q  <= 1'b0;
      trap_code_q <= '0;
    end else begin
      state_q     <= state_d;
      ack_q       <= accept;
      trap_req_q  <= trap_req_d;
      trap_code_q <= trap_code_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    trap_req_d  = trap_req_q;
    trap_code_d = trap_code_q;
    pop         = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.irq_en_i && (count != '0)) begin
          state_d     = REQ;
          trap_req_d  = 1'b1;
          trap_code_d = head_dat;
        end
      end
      // Once raised, the request is not withdrawn by the enable dropping
      REQ: begin
        if (bus.trap_ack_i) begin
          state_d    = SERVICE;
          trap_req_d = 1'b0;
          pop        = 1'b1;
        end
      end
      SERVICE: begin
        if (bus.irq_ret_i) begin
          state_d     = IDLE;
          trap_code_d = '0;
        end
      end
      default: begin
        state_d     = IDLE;
        trap_req_d  = 1'b0;
        trap_code_d = '0;
      end
    endcase
  end

  assign bus.irq_ack_o      = ack_q;
  assign bus.trap_req_o     = trap_req_q;
  assign bus.trap_code_bo   = trap_code_q;
  assign bus.pending_cnt_bo = count;
  assign bus.busy_o         = (state_q != IDLE);
endmodule

// File: tb/tb_irq_receiver.sv
// Directed bench for irq_receiver: vector table for the single-step behaviour, hand sequences
// for FIFO backpressure, asynchronous reset and code-zero handling.
module tb_irq_receiver;
  localparam int DEPTH = 4;
  localparam int CW    = 8;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk_i = ~clk_i;

  irq_receiver_if #(.FIFO_DEPTH(DEPTH), .CODE_WIDTH(CW)) bus ();

  irq_receiver #(.FIFO_DEPTH(DEPTH), .CODE_WIDTH(CW)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  typedef struct {
    logic       req;
    logic [7:0] code;
    logic       en;
    logic       tack;
    logic       ret;
    logic       ack;
    logic       treq;
    logic [7:0] tcode;
    logic [2:0] cnt;
    logic       busy;
  } vec_t;

  vec_t vecs[22];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  function automatic logic [13:0] outs();
    return {bus.irq_ack_o, bus.trap_req_o, bus.trap_code_bo, bus.pending_cnt_bo, bus.busy_o};
  endfunction

  // Present a code and hold it until acked or the budget runs out
  task automatic send(input logic [7:0] c, output bit acked);
    acked = 1'b0;
    bus.irq_req_i   = 1'b1;
    bus.irq_code_bi = c;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (bus.irq_ack_o) begin
        acked = 1'b1;
        break;
      end
    end
    bus.irq_req_i   = 1'b0;
    bus.irq_code_bi = '0;
  endtask

  task automatic wait_treq(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus.trap_req_o) begin
        seen = 1'b1;
        break;
      end
      cycle();
    end
  endtask

  task automatic take_and_return();
    bus.trap_ack_i = 1'b1;
    cycle();
    bus.trap_ack_i = 1'b0;
    bus.irq_ret_i  = 1'b1;
    cycle();
    bus.irq_ret_i  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    bit seen;

    //         req code   en tack ret | ack treq tcode cnt busy
    vecs[0]  = '{1, 8'h03, 1, 0, 0,  1, 0, 8'h00, 3'd1, 0};
    vecs[1]  = '{0, 8'h00, 1, 0, 0,  0, 1, 8'h03, 3'd1, 1};
    vecs[2]  = '{0, 8'h00, 0, 0, 0,  0, 1, 8'h03, 3'd1, 1};
    vecs[3]  = '{0, 8'h00, 0, 1, 0,  0, 0, 8'h03, 3'd0, 1};
    vecs[4]  = '{0, 8'h00, 0, 1, 0,  0, 0, 8'h03, 3'd0, 1};
    vecs[5]  = '{0, 8'h00, 0, 0, 1,  0, 0, 8'h00, 3'd0, 0};
    vecs[6]  = '{1, 8'h0A, 0, 0, 0,  1, 0, 8'h00, 3'd1, 0};
    vecs[7]  = '{1, 8'h0A, 0, 0, 0,  0, 0, 8'h00, 3'd1, 0};
    vecs[8]  = '{1, 8'h0A, 0, 0, 0,  1, 0, 8'h00, 3'd2, 0};
    vecs[9]  = '{0, 8'h00, 0, 0, 0,  0, 0, 8'h00, 3'd2, 0};
    vecs[10] = '{0, 8'h00, 1, 0, 0,  0, 1, 8'h0A, 3'd2, 1};
    vecs[11] = '{0, 8'h00, 1, 1, 0,  0, 0, 8'h0A, 3'd1, 1};
    vecs[12] = '{0, 8'h00, 1, 0, 1,  0, 0, 8'h00, 3'd1, 0};
    vecs[13] = '{0, 8'h00, 1, 0, 0,  0, 1, 8'h0A, 3'd1, 1};
    vecs[14] = '{0, 8'h00, 1, 1, 0,  0, 0, 8'h0A, 3'd0, 1};
    vecs[15] = '{0, 8'h00, 1, 0, 1,  0, 0, 8'h00, 3'd0, 0};
    vecs[16] = '{0, 8'h00, 1, 0, 1,  0, 0, 8'h00, 3'd0, 0};
    vecs[17] = '{1, 8'h22, 1, 0, 0,  1, 0, 8'h00, 3'd1, 0};
    vecs[18] = '{0, 8'h00, 1, 0, 1,  0, 1, 8'h22, 3'd1, 1};
    vecs[19] = '{0, 8'h00, 1, 0, 1,  0, 1, 8'h22, 3'd1, 1};
    vecs[20] = '{0, 8'h00, 1, 1, 0,  0, 0, 8'h22, 3'd0, 1};
    vecs[21] = '{0, 8'h00, 1, 0, 1,  0, 0, 8'h00, 3'd0, 0};

    bus.irq_req_i   = 1'b0;
    bus.irq_code_bi = '0;
    bus.irq_en_i    = 1'b0;
    bus.trap_ack_i  = 1'b0;
    bus.irq_ret_i   = 1'b0;

    #12;
    check("reset_outputs", 32'(outs()), 32'h0);
`ifdef IRQ_RECV_SPURIOUS_EN
    check("reset_spurious", 32'(bus.spurious_cnt_bo), 32'h0);
`endif
    @(negedge clk_i);
    rst_i = 1'b0;

    for (int i = 0; i < 22; i++) begin
      bus.irq_req_i   = vecs[i].req;
      bus.irq_code_bi = vecs[i].code;
      bus.irq_en_i    = vecs[i].en;
      bus.trap_ack_i  = vecs[i].tack;
      bus.irq_ret_i   = vecs[i].ret;
      cycle();
      check($sformatf("vec%0d", i), 32'(outs()),
            32'({vecs[i].ack, vecs[i].treq, vecs[i].tcode, vecs[i].cnt, vecs[i].busy}));
    end
    bus.irq_req_i  = 1'b0;
    bus.irq_code_bi = '0;
    bus.trap_ack_i = 1'b0;
    bus.irq_ret_i  = 1'b0;

    // Fill the FIFO with interrupts disabled, then hold a fifth code
    bus.irq_en_i = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      send(k[7:0], ok);
      check($sformatf("fill_ack%0d", k), 32'(ok), 32'h1);
    end
    check("fill_cnt", 32'(bus.pending_cnt_bo), 32'd4);
    bus.irq_req_i   = 1'b1;
    bus.irq_code_bi = 8'h05;
    seen = 1'b0;
    repeat (6) begin
      cycle();
      if (bus.irq_ack_o) seen = 1'b1;
    end
    check("full_no_ack", 32'(seen), 32'h0);
    check("full_cnt", 32'(bus.pending_cnt_bo), 32'd4);
    bus.irq_en_i = 1'b1;
    cycle();
    check("full_req", 32'({bus.trap_req_o, bus.trap_code_bo, bus.pending_cnt_bo}),
          32'({1'b1, 8'h01, 3'd4}));
    bus.trap_ack_i = 1'b1;
    cycle();
    bus.trap_ack_i = 1'b0;
    check("pop_no_push", 32'({bus.irq_ack_o, bus.pending_cnt_bo}), 32'({1'b0, 3'd3}));
    cycle();
    check("late_ack", 32'({bus.irq_ack_o, bus.pending_cnt_bo}), 32'({1'b1, 3'd4}));
    bus.irq_req_i   = 1'b0;
    bus.irq_code_bi = '0;
    bus.irq_ret_i   = 1'b1;
    cycle();
    bus.irq_ret_i   = 1'b0;
    for (int k = 2; k <= 5; k++) begin
      wait_treq(seen);
      check($sformatf("order_req%0d", k), 32'(seen), 32'h1);
      check($sformatf("order_code%0d", k), 32'(bus.trap_code_bo), 32'(k));
      take_and_return();
    end
    check("drain_idle", 32'({bus.pending_cnt_bo, bus.busy_o}), 32'h0);

    // Asynchronous reset while servicing with two codes queued
    bus.irq_en_i = 1'b1;
    send(8'h11, ok);
    wait_treq(seen);
    bus.trap_ack_i = 1'b1;
    cycle();
    bus.trap_ack_i = 1'b0;
    bus.irq_en_i   = 1'b0;
    send(8'h12, ok);
    send(8'h13, ok);
    check("pre_reset", 32'({bus.trap_code_bo, bus.pending_cnt_bo, bus.busy_o}),
          32'({8'h11, 3'd2, 1'b1}));
    #2;
    rst_i = 1'b1;
    #1;
    check("async_reset", 32'(outs()), 32'h0);
    @(negedge clk_i);
    rst_i = 1'b0;
    bus.irq_en_i = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      cycle();
      if (bus.trap_req_o) seen = 1'b1;
    end
    check("post_reset_quiet", 32'({seen, bus.pending_cnt_bo}), 32'h0);

    // Code zero handling
    bus.irq_en_i = 1'b0;
`ifdef IRQ_RECV_SPURIOUS_EN
    send(8'h00, ok);
    check("spur_ack0", 32'(ok), 32'h1);
    send(8'h07, ok);
    check("spur_ack7", 32'(ok), 32'h1);
    check("spur_cnt", 32'({bus.spurious_cnt_bo, bus.pending_cnt_bo}), 32'({8'd1, 3'd1}));
    bus.irq_en_i = 1'b1;
    wait_treq(seen);
    check("spur_deliver", 32'({seen, bus.trap_code_bo}), 32'({1'b1, 8'h07}));
    take_and_return();
    check("spur_empty", 32'(bus.pending_cnt_bo), 32'h0);
`else
    send(8'h00, ok);
    check("zero_ack", 32'(ok), 32'h1);
    check("zero_queued", 32'(bus.pending_cnt_bo), 32'd1);
    bus.irq_en_i = 1'b1;
    wait_treq(seen);
    check("zero_deliver", 32'({seen, bus.trap_code_bo, bus.busy_o}), 32'({1'b1, 8'h00, 1'b1}));
    take_and_return();
    check("zero_empty", 32'({bus.pending_cnt_bo, bus.busy_o}), 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
